// File: rtl/axi_sram_slave.sv
// AXI3 slave over an internal word array; independent read and write FSMs (optional AXI_SLV_RAND_DELAY_EN stalls).
// Latency: rvalid the cycle after the AR handshake, wready the cycle after AW, bvalid the cycle after the final W beat.
// Backpressure: rvalid/rdata/rlast hold under rready=0, bvalid holds under bready=0; one burst per channel in flight.
module axi_sram_slave #(
    parameter int ADDR_W    = 12,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Contents survive reset; only the simulation start value is configurable.
    logic [31:0] mem [0:(1<<ADDR_W)-1] = '{default: (INIT_ZERO ? 32'h0 : {32{1'bx}})};

    logic              hold;
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_addr, r_addr_nxt, ar_word;
    logic [7:0]        r_len, r_cnt;
    logic              r_fixed;
    logic [1:0]        w_state;
    logic [ADDR_W-1:0] w_addr, w_addr_nxt, aw_word;
    logic [7:0]        w_len, w_cnt;
    logic              w_fixed, w_fire, w_last_beat;
    logic [3:0]        w_id;
    logic              unused_ok;

`ifdef AXI_SLV_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign hold = (lfsr[1:0] == 2'b00);
`else
    assign hold = 1'b0;
`endif

    assign ar_word     = araddr[ADDR_W+1:2];
    assign aw_word     = awaddr[ADDR_W+1:2];
    assign r_addr_nxt  = r_fixed ? r_addr : r_addr + ADDR_ONE;
    assign w_addr_nxt  = w_fixed ? w_addr : w_addr + ADDR_ONE;
    assign w_fire      = wvalid && wready;
    assign w_last_beat = (w_cnt == w_len);
    assign unused_ok   = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot, wid,
                           araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};

    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // rdata is fetched one beat ahead so it is already registered when rvalid rises.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= 4'd0;
            rdata   <= 32'd0;
            rresp   <= 2'b00;
            r_addr  <= '0;
            r_len   <= 8'd0;
            r_cnt   <= 8'd0;
            r_fixed <= 1'b0;
        end else if (r_state == R_IDLE) begin
            if (arvalid && arready) begin
                r_state <= R_DATA;
                arready <= 1'b0;
                rid     <= arid;
                r_addr  <= ar_word;
                r_len   <= arlen;
                r_cnt   <= 8'd0;
                r_fixed <= (arburst == 2'b00);
                rdata   <= mem[ar_word];
                rlast   <= (arlen == 8'd0);
                rvalid  <= !hold;
            end else begin
                arready <= !hold;
            end
        end else if (!rvalid) begin
            rvalid <= !hold;
        end else if (rready) begin
            if (r_cnt == r_len) begin
                rvalid  <= 1'b0;
                rlast   <= 1'b0;
                arready <= !hold;
                r_state <= R_IDLE;
            end else begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= r_addr_nxt;
                rdata  <= mem[r_addr_nxt];
                rlast  <= (r_cnt + 8'd1 == r_len);
                rvalid <= !hold;
            end
        end
    end

    // A burst closes on wlast or the beat count, whichever comes first; any disagreement is SLVERR.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= 4'd0;
            bresp   <= 2'b00;
            w_id    <= 4'd0;
            w_addr  <= '0;
            w_len   <= 8'd0;
            w_cnt   <= 8'd0;
            w_fixed <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_state <= W_DATA;
                        awready <= 1'b0;
                        wready  <= !hold;
                        w_id    <= awid;
                        w_addr  <= aw_word;
                        w_len   <= awlen;
                        w_cnt   <= 8'd0;
                        w_fixed <= (awburst == 2'b00);
                    end else begin
                        awready <= !hold;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (wlast || w_last_beat) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= (wlast != w_last_beat) ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= w_addr_nxt;
                            wready <= !hold;
                        end
                    end else begin
                        wready <= !hold;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= !hold;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts, strobes, stalls, early wlast, address wrap and mid-burst reset.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, rready, awvalid, wlast, wvalid, bready;
    logic        arready, rlast, rvalid, awready, wready, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [16];
    logic        rl [16];
    logic [3:0]  r_id_got, b_id_got;
    logic [1:0]  b_resp_got;
    logic        first_vld, w_ready_after;
    logic [3:0]  rpat;

    axi_sram_slave #(.ADDR_W(12), .INIT_ZERO(1'b1)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return arready;
            1:       return awready;
            2:       return wready;
            3:       return bvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hi(input string tag, input int sel);
        int t = 0;
        @(negedge aclk);
        while (!sig(sel) && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (!sig(sel)) check({tag, "_tmo"}, 32'd0, 32'd1);
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int nbeats);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        wait_hi("aw", 1);
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1); wvalid = 1'b1;
            wait_hi("w", 2);
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        w_ready_after = wready;
        bready = 1'b1;
        wait_hi("b", 3);
        b_id_got = bid; b_resp_got = bresp;
        @(posedge aclk); #1 bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst);
        int got = 0;
        int cyc = 0;
        logic stall = 1'b0;
        logic [31:0] hd = 32'd0;
        logic hl = 1'b0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        wait_hi("ar", 0);
        @(posedge aclk); #1 arvalid = 1'b0;
        while (got <= int'(len) && cyc < 300) begin
            @(negedge aclk);
            if (cyc == 0) first_vld = rvalid;
            rready = rpat[cyc % 4];
            cyc++;
            if (stall) begin
                check("hold_vld", {31'd0, rvalid}, 32'd1);
                check("hold_dat", rdata, hd);
                check("hold_last", {31'd0, rlast}, {31'd0, hl});
            end
            stall = 1'b0;
            if (rvalid) begin
                if (rready) begin
                    if (got < 16) begin
                        rd[got] = rdata;
                        rl[got] = rlast;
                    end
                    r_id_got = rid;
                    got++;
                end else begin
                    stall = 1'b1; hd = rdata; hl = rlast;
                end
            end
        end
        if (got <= int'(len)) check("r_tmo", got, int'(len) + 1);
        @(posedge aclk); #1 rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 3'b010; arburst = 2'b01; arlock = 0; arcache = 0; arprot = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'b010; awburst = 2'b01; awlock = 0; awcache = 0; awprot = 0;
        arvalid = 0; rready = 0; awvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        rpat = 4'b1111;
        #1;
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_valids", {29'd0, rvalid, bvalid, rlast}, 32'd0);
        check("rst_ids", {24'd0, rid, bid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", {28'd0, rresp, bresp}, 32'd0);
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        #1 check("rel_arready_pre", {31'd0, arready}, 32'd0);
        @(posedge aclk); #1;
        check("rel_arready", {31'd0, arready}, 32'd1);
        check("rel_awready", {31'd0, awready}, 32'd1);

        // single-beat write and read back
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(4'd5, 32'h100, 8'd0, 2'b01, 1);
        check("t1_bresp", {30'd0, b_resp_got}, 32'd0);
        check("t1_bid", {28'd0, b_id_got}, 32'd5);
        axi_read(4'd3, 32'h100, 8'd0, 2'b01);
        check("t1_lat", {31'd0, first_vld}, 32'd1);
        check("t1_data", rd[0], 32'hDEADBEEF);
        check("t1_rid", {28'd0, r_id_got}, 32'd3);
        check("t1_rlast", {31'd0, rl[0]}, 32'd1);
        axi_read(4'd0, 32'h103, 8'd0, 2'b01);
        check("t1_lowbits", rd[0], 32'hDEADBEEF);

        // INCR write/read and FIXED read
        for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
        axi_write(4'd2, 32'h200, 8'd3, 2'b01, 4);
        check("t2_bresp", {30'd0, b_resp_got}, 32'd0);
        axi_read(4'd7, 32'h200, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            check("t2_incr_dat", rd[i], i + 1);
            check("t2_incr_last", {31'd0, rl[i]}, (i == 3) ? 32'd1 : 32'd0);
        end
        axi_read(4'd7, 32'h200, 8'd3, 2'b00);
        for (int i = 0; i < 4; i++) check("t2_fixed_dat", rd[i], 32'd1);
        check("t2_fixed_last", {30'd0, rl[0], rl[3]}, 32'd1);

        // byte strobes
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        axi_write(4'd1, 32'h300, 8'd0, 2'b01, 1);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        axi_write(4'd1, 32'h300, 8'd0, 2'b01, 1);
        axi_read(4'd1, 32'h300, 8'd0, 2'b01);
        check("t3_strb", rd[0], 32'h11BB33DD);

        // rready stalls 1,0,0,1
        rpat = 4'b1001;
        axi_read(4'd4, 32'h200, 8'd3, 2'b01);
        rpat = 4'b1111;
        for (int i = 0; i < 4; i++) check("t4_stall_dat", rd[i], i + 1);
        check("t4_stall_last", {28'd0, rl[3], rl[2], rl[1], rl[0]}, 32'b1000);

        // early wlast: SLVERR, remaining words untouched
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        axi_write(4'd6, 32'h400, 8'd3, 2'b01, 4);
        wd[0] = 32'hB0; wd[1] = 32'hB1;
        axi_write(4'd9, 32'h400, 8'd3, 2'b01, 2);
        check("t5_wready_after", {31'd0, w_ready_after}, 32'd0);
        check("t5_bresp", {30'd0, b_resp_got}, 32'd2);
        check("t5_bid", {28'd0, b_id_got}, 32'd9);
        axi_read(4'd0, 32'h400, 8'd3, 2'b01);
        check("t5_d0", rd[0], 32'hB0);
        check("t5_d1", rd[1], 32'hB1);
        check("t5_d2", rd[2], 32'hA2);
        check("t5_d3", rd[3], 32'hA3);

        // word address wraps at 2^12 words, upper bits alias
        wd[0] = 32'hC0; wd[1] = 32'hC1; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(4'd2, 32'h3FFC, 8'd1, 2'b01, 2);
        axi_read(4'd0, 32'h0, 8'd0, 2'b01);
        check("t6_wrap", rd[0], 32'hC1);
        axi_read(4'd0, 32'h4000, 8'd0, 2'b01);
        check("t6_alias", rd[0], 32'hC1);
        axi_read(4'd0, 32'h3FFC, 8'd1, 2'b01);
        check("t6_rd_wrap0", rd[0], 32'hC0);
        check("t6_rd_wrap1", rd[1], 32'hC1);

        // reset in the middle of an 8-beat read
        arid = 4'd2; araddr = 32'h200; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
        wait_hi("ar", 0);
        @(posedge aclk); #1 arvalid = 1'b0;
        rready = 1'b1;
        @(posedge aclk); @(posedge aclk);
        #3 rready = 1'b0; areset = 1'b1;
        #1;
        check("t7_rvalid", {31'd0, rvalid}, 32'd0);
        check("t7_rlast", {31'd0, rlast}, 32'd0);
        check("t7_arready", {31'd0, arready}, 32'd0);
        check("t7_rdata", rdata, 32'd0);
        #2 areset = 1'b0;
        #1 check("t7_arready_pre", {31'd0, arready}, 32'd0);
        @(posedge aclk); #1;
        check("t7_arready_post", {31'd0, arready}, 32'd1);
        check("t7_awready_post", {31'd0, awready}, 32'd1);
        axi_read(4'd8, 32'h200, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) check("t7_after_dat", rd[i], i + 1);
        check("t7_after_rid", {28'd0, r_id_got}, 32'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3-style slave responder backed by an internal 32-bit word register array.
- Terminates the CPU's AXI master port in block-level and SoC-less simulation, and serves as a small on-chip RAM.
- Read and write channels run independent state machines, so one read burst and one write burst may be in flight at the same time.

Parameters:
- ADDR_W, 12, word-address width; the array holds 2^ADDR_W words and uses addr[ADDR_W+1:2].
- INIT_ZERO, 1, when 1 the array is zeroed at time 0 (simulation only); it is never cleared by reset.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- arid  in  4  read ID
- araddr  in  32  read byte address
- arlen  in  8  read beats-1
- arsize  in  3  ignored, 4-byte beats only
- arburst  in  2  00 FIXED, 01 INCR, others treated as INCR
- arlock/arcache/arprot  in  2/4/3  ignored
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  4  read ID echo
- rdata  out  32  read data
- rresp  out  2  always 00
- rlast  out  1  last read beat
- rvalid  out  1  R valid
- rready  in  1  R ready
- awid  in  4  write ID
- awaddr  in  32  write byte address
- awlen  in  8  write beats-1
- awsize  in  3  ignored
- awburst  in  2  same encoding as arburst
- awlock/awcache/awprot  in  2/4/3  ignored
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wid  in  4  ignored
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  last write beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  4  write ID echo
- bresp  out  2  00 OKAY, 10 SLVERR
- bvalid  out  1  B valid
- bready  in  1  B ready

Behaviour:
- Reset values (all outputs registered): arready=0, awready=0, wready=0, rvalid=0, rlast=0, bvalid=0, rid=0, bid=0, rdata=0, rresp=0, bresp=0. Both FSMs go to IDLE.
- First edge after reset release: arready=1, awready=1.
- Reset asserted mid-burst aborts the burst immediately; array contents are kept.
- Read FSM R_IDLE/R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, latch id, word addr, len; clear beat counter; arready<=0; go to R_DATA.
  - R_DATA: rvalid asserted the cycle after the AR handshake, so read latency is 1 cycle. rdata=mem[addr], rid=latched id, rlast=(cnt==len).
  - rvalid, rdata and rlast stay stable while rready=0.
  - On each rvalid&rready: cnt+1; addr+1 for INCR, unchanged for FIXED; next beat presented the following cycle.
  - On the last handshake: rvalid=0, arready=1, back to R_IDLE. Back-to-back bursts therefore have one idle cycle between them.
- Write FSM W_IDLE/W_DATA/W_RESP:
  - W_IDLE: awready=1, wready=0. W beats arriving before AW are held off.
  - On the AW handshake: latch id, addr, len; cnt=0; err=0; go to W_DATA with wready=1 the next cycle.
  - Each wvalid&wready writes the bytes of mem[addr] selected by wstrb and advances addr as for reads.
  - err is set if wlast=1 with cnt!=len, or wlast=0 with cnt==len.
  - The burst ends on wlast or cnt==len, whichever comes first. Then wready=0 and the FSM enters W_RESP with bvalid=1, bid=latched id, bresp=err?10:00. Any extra beats stay unaccepted, and the master must drop them.
  - On bvalid&bready: bvalid=0, back to W_IDLE.
- Address arithmetic:
  - Word address wraps modulo 2^ADDR_W; bits above ADDR_W+1 alias.
  - addr[1:0] is ignored.
  - A 256-beat burst (len=255) is legal.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data. There is no ordering between channels; a master needing ordering waits for B.

Optional Feature:
- Macro AXI_SLV_RAND_DELAY_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1 on reset, x^16+x^14+x^13+x^11) gates arready, awready, wready and the first rvalid of each beat.
  - The ready or valid is held low on cycles where lfsr[1:0]==2'b00.
  - Protocol rules still hold: a valid, once asserted, is never dropped before its handshake.
- Undefined: no LFSR logic; timing exactly as in Behaviour.

Test Plan:
- AW addr 0x100 len 0, W 0xDEADBEEF strb F -> B bresp 00 bid=awid. AR 0x100 len 0 id 3 -> one beat 0xDEADBEEF, rid 3, rlast 1, rvalid the cycle after the AR handshake.
- INCR write of 4 beats at 0x200 with data 1,2,3,4, then INCR read of 4 beats -> data 1,2,3,4 with rlast only on beat 4. FIXED read of 4 beats at 0x200 -> 1,1,1,1.
- Word 0x300 = 0x11223344, then write 0xAABBCCDD with strb 0101 -> reads back 0x11BB33DD.
- Read burst with rready toggling 1,0,0,1 -> rdata and rlast held stable through the stalls, with no beat skipped or repeated.
- AW len 3 with wlast on beat 2 -> bresp 10 after beat 2, wready low afterwards. A following read shows beats 1-2 written and beats 3-4 unchanged.
- areset pulsed mid 8-beat read -> all valids 0 asynchronously, arready 1 on the first edge after release, and a new read returns correct data.
